// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer helpers and read-side FSM state type
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        HALT   = 2'd2
    } state_t;

    // Pointer width for a given depth: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Unread-entry count, modulo 2^width; shared with the write side for its full test.
    function automatic logic [31:0] ptr_level(input logic [31:0] wr, input logic [31:0] rd,
                                              input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// rtl/fifo_read_ctrl_if.sv - valid/ready output stream of the FIFO read controller
interface fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_out_reg.sv
// rtl/fifo_out_reg.sv - registered valid/ready output stage with load, accept and clear
module fifo_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read pointer, fetch/overrun FSM and output stream
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int PTR_W     = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W:0]       wr_ptr,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  flush,
    fifo_read_ctrl_if.master      m,
    output logic                  empty,
    output logic [ADDR_W:0]       level,
    output logic                  overrun
);

    logic [ADDR_W:0] rd_ptr;
    state_t          state;
    state_t          state_nxt;
    logic            fetch;
    logic            accept;
    logic            overflow;

    assign mem_rd_addr = rd_ptr[ADDR_W-1:0];
    assign empty       = (wr_ptr == rd_ptr);
    assign level       = PTR_W'(ptr_level(32'(wr_ptr), 32'(rd_ptr), PTR_W));
    // level == DEPTH is a legal full FIFO; only beyond that has the writer lapped us.
    assign overflow    = level[ADDR_W] && (|level[ADDR_W-1:0]);
    assign accept      = m.valid && m.ready;
    assign fetch       = (state != HALT) && !empty && (!m.valid || m.ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch) state_nxt = STREAM;
            STREAM:  if (accept && !fetch) state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        if (overflow) state_nxt = HALT;
        if (flush)    state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            overrun <= 1'b0;
            state   <= IDLE;
        end else begin
            state <= state_nxt;
            if (flush) begin
                rd_ptr  <= wr_ptr;
                overrun <= 1'b0;
            end else begin
                if (fetch)    rd_ptr  <= rd_ptr + 1'b1;
                if (overflow) overrun <= 1'b1;
            end
        end
    end

    fifo_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush || (state == HALT)),
        .load      (fetch && !flush),
        .load_data (mem_rd_data),
        .ready     (m.ready),
        .valid     (m.valid),
        .data      (m.data)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   wr_ptr;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          flush;
    logic          empty;
    logic [AW:0]   level;
    logic          overrun;
    logic [DW-1:0] mem [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    fifo_read_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

    fifo_read_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ptr      (wr_ptr),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .flush       (flush),
        .m           (m_if),
        .empty       (empty),
        .level       (level),
        .overrun     (overrun)
    );

    assign mem_rd_data = mem[mem_rd_addr];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [DW-1:0] v);
        mem[wr_ptr[AW-1:0]] = v;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_ptr = '0;
        flush = 1'b0;
        m_if.ready = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 6;
        if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", m_if.valid); end
        if (m_if.data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h expected 0", m_if.data); end
        if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
        if (mem_rd_addr !== 4'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", mem_rd_addr); end
        step();
        n_cmp++;
        if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %0b expected 0", m_if.valid); end
    endtask

    task automatic test_single();
        m_if.ready = 1'b1;
        write_entry(8'hA5);
        step();
        n_cmp += 2;
        if (m_if.valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b expected 1", m_if.valid); end
        if (m_if.data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %0h expected a5", m_if.data); end
        step();
        n_cmp += 2;
        if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL single_drop: got %0b expected 0", m_if.valid); end
        if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_backpressure();
        m_if.ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            write_entry(8'(8'h10 + i));
            step();
        end
        step();
        n_cmp += 3;
        if (m_if.valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %0b expected 1", m_if.valid); end
        if (m_if.data !== 8'h10) begin n_err++; $display("FAIL bp_hold: got %0h expected 10", m_if.data); end
        if (level !== 5'd15) begin n_err++; $display("FAIL bp_level: got %0d expected 15", level); end
        m_if.ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            step();
            n_cmp++;
            if (m_if.valid !== 1'b1 || m_if.data !== 8'(8'h10 + i)) begin
                n_err++;
                $display("FAIL bp_stream[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i, m_if.valid, m_if.data, 8'(8'h10 + i));
            end
        end
        step();
        n_cmp++;
        if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL bp_end: got %0b expected 0", m_if.valid); end
    endtask

    // Reference: entries leave in write order; a write is allowed only while
    // the unconsumed count (memory plus output register) stays within DEPTH.
    task automatic test_wrap();
        logic [DW-1:0] exp_q[$];
        int written = 0;
        int accepted = 0;
        int cycles = 0;
        do_reset();
        while (accepted < 40 && cycles < 2000) begin
            if (written < 40 && (written - accepted) < DEPTH && $urandom_range(0, 3) != 0) begin
                write_entry(8'(written));
                exp_q.push_back(8'(written));
                written++;
            end
            m_if.ready = ($urandom_range(0, 3) != 0);
            if (m_if.valid && m_if.ready) begin
                n_cmp++;
                if (exp_q.size() == 0 || m_if.data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL wrap_order[%0d]: got %0h expected %0h", accepted, m_if.data,
                             (exp_q.size() == 0) ? 8'hxx : exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                accepted++;
            end
            step();
            cycles++;
        end
        n_cmp += 3;
        if (accepted != 40) begin n_err++; $display("FAIL wrap_timeout: got %0d accepted expected 40", accepted); end
        if (mem_rd_addr !== 4'd8) begin n_err++; $display("FAIL wrap_addr: got %0d expected 8", mem_rd_addr); end
        if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %0b expected 1", empty); end
        m_if.ready = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            write_entry(8'(8'h40 + i));
            step();
            if (i == 16) begin
                n_cmp += 2;
                if (level !== 5'd16) begin n_err++; $display("FAIL ovr_full_level: got %0d expected 16", level); end
                if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_full_legal: got %0b expected 0", overrun); end
            end
        end
        n_cmp++;
        if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b expected 1", overrun); end
        m_if.ready = 1'b1;
        step();
        step();
        n_cmp += 2;
        if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid: got %0b expected 0", m_if.valid); end
        if (mem_rd_addr !== 4'd1) begin n_err++; $display("FAIL ovr_nofetch: got %0d expected 1", mem_rd_addr); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp += 5;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL flush_overrun: got %0b expected 0", overrun); end
        if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %0b expected 1", empty); end
        if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b expected 0", m_if.valid); end
        if (level !== 5'd0) begin n_err++; $display("FAIL flush_level: got %0d expected 0", level); end
        if (mem_rd_addr !== wr_ptr[AW-1:0]) begin n_err++; $display("FAIL flush_addr: got %0d expected %0d", mem_rd_addr, wr_ptr[AW-1:0]); end
        write_entry(8'h77);
        step();
        n_cmp++;
        if (m_if.valid !== 1'b1 || m_if.data !== 8'h77) begin
            n_err++;
            $display("FAIL flush_resume: got v=%0b d=%0h expected v=1 d=77", m_if.valid, m_if.data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        m_if.ready = 1'b0;
        write_entry(8'h5A);
        write_entry(8'h5B);
        step();
        step();
        n_cmp++;
        if (m_if.valid !== 1'b1 || m_if.data !== 8'h5A) begin
            n_err++;
            $display("FAIL ar_pre: got v=%0b d=%0h expected v=1 d=5a", m_if.valid, m_if.data);
        end
        #2;
        rst = 1'b0;
        wr_ptr = '0;
        #1;
        n_cmp += 3;
        if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %0b expected 0", m_if.valid); end
        if (m_if.data !== 8'h00) begin n_err++; $display("FAIL ar_data: got %0h expected 0", m_if.data); end
        if (mem_rd_addr !== 4'd0) begin n_err++; $display("FAIL ar_addr: got %0d expected 0", mem_rd_addr); end
        step();
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the team's single-clock circular FIFO memory. It owns the read pointer and drives the memory's read address. It compares against the write pointer exported by the write side and drains entries into a registered valid/ready output stream. It also detects overrun (writer lapping the reader) and supports a synchronous flush.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry
DEPTH, 16, number of memory entries; power of two, >= 2
ADDR_W, $clog2(DEPTH), memory address width (derived; not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
wr_ptr  input  ADDR_W+1  write-side pointer, MSB = wrap bit, same clock domain, advances by at most 1 per cycle
mem_rd_addr  output  ADDR_W  read address to memory array; memory returns data combinationally
mem_rd_data  input  DATA_WIDTH  memory read data for mem_rd_addr
flush  input  1  synchronous: discard all unread data
m_valid  output  1  output entry valid
m_ready  input  1  consumer accepts entry when m_valid && m_ready
m_data  output  DATA_WIDTH  output entry
empty  output  1  no unread entries in memory (excludes the output register)
level  output  ADDR_W+1  unread entries in memory = (wr_ptr - rd_ptr) mod 2^(ADDR_W+1)
overrun  output  1  sticky error: writer overwrote unread data

Behaviour:
- Internal rd_ptr [ADDR_W:0]; mem_rd_addr = rd_ptr[ADDR_W-1:0] (combinational).
- Reset (rst=0, async): rd_ptr=0, m_valid=0, m_data=0, overrun=0, state=IDLE.
- empty = (wr_ptr == rd_ptr). level is computed combinationally with modulo-2^(ADDR_W+1) subtraction.
- fetch = (state != HALT) && !empty && (!m_valid || m_ready).
- On a fetch clock edge: m_data <= mem_rd_data, m_valid <= 1, rd_ptr <= rd_ptr+1. rd_ptr wraps naturally, and the wrap bit toggles at DEPTH.
- On m_valid && m_ready without a fetch: m_valid <= 0. m_data holds its last value.
- Simultaneous accept and fetch gives back-to-back streaming: 1 entry/cycle sustained.
- Latency: wr_ptr advances at edge N, so the entry appears on m_data with m_valid=1 after edge N+1 (one cycle).
- m_data/m_valid are stable while m_valid && !m_ready.
- Overrun: level > DEPTH (i.e. level[ADDR_W]=1 with nonzero low bits) in any cycle → overrun <= 1, state <= HALT.
- FSM states:
  - IDLE: m_valid=0, memory empty. Goes to STREAM on fetch.
  - STREAM: m_valid=1 or fetch pending. Goes to IDLE when m_valid would drop and memory is empty.
  - HALT: no fetches. m_valid is forced to 0 on the next edge.
- flush (any state, higher priority than fetch and overrun detection in that cycle): rd_ptr <= wr_ptr, m_valid <= 0, overrun <= 0, state <= IDLE.
- level == DEPTH (full) is legal and is not overrun.
- Reset mid-stream: all state clears immediately. The write side is expected to reset its pointer concurrently.

Decomposition:
- Shared package fifo_pkg holds:
  - ptr_t width helper (ADDR_W+1).
  - FSM state enum {IDLE, STREAM, HALT}.
  - Function ptr_level(wr, rd) returning the modulo difference, so the write side can reuse the same full computation.
- One natural sub-module, fifo_out_reg: the valid/ready output register with load/accept logic. The pointer/FSM logic stays in the top.

Test Plan:
1. Reset then idle: rst low 2 cycles, wr_ptr=0 → m_valid=0, m_data=0, empty=1, level=0, overrun=0, mem_rd_addr=0.
2. Single entry: mem[0]=0xA5, wr_ptr 0→1 at edge N, m_ready=1 → m_valid=1 and m_data=0xA5 after edge N+1, m_valid=0 after edge N+2, empty=1.
3. Back-pressure and streaming:
   - DEPTH=16, write 0x10..0x1F (wr_ptr=16), m_ready=0 → m_valid=1 holding 0x10, level=15.
   - Then m_ready=1 → 0x11..0x1F delivered on consecutive cycles, no gaps or duplicates.
4. Wrap-around: stream 40 entries of value i through at steady rate → rd_ptr reaches 40 mod 32 = 8, mem_rd_addr=8, data order intact across both wraps.
5. Overrun: m_ready=0, writer advances wr_ptr to rd_ptr+17 → overrun=1 the next cycle, m_valid=0 and no further fetches. flush=1 for one cycle → overrun=0, rd_ptr=wr_ptr, empty=1, m_valid=0.
6. Async reset mid-stream: assert rst between clock edges while m_valid=1 → m_valid, m_data and rd_ptr are 0 immediately, without waiting for a clock edge.
